// File: rtl/video_out_gen.sv
// Raster-timed pixel output stage: pops 8-bit pixels from a show-ahead FIFO and
// emits them with fixed horizontal/vertical blanking, underflow and frame-done flags.
module video_out_gen #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_BLANK = 160,
    parameter int V_BLANK = 45
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       enable,
    input  logic       empty,
    input  logic [7:0] pixel_in,
    output logic       r_e,
    output logic [7:0] pixel_out,
    output logic       line_valid,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       underflow
);

    localparam int H_TOTAL = WIDTH + H_BLANK;
    localparam int V_TOTAL = HEIGHT + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(WIDTH - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [HW-1:0] r_h_cnt;
    logic [HW-1:0] w_h_next;
    logic [VW-1:0] r_v_cnt;
    logic [VW-1:0] w_v_next;
    logic          w_start;
    logic          w_frame_end;
    logic          w_line_end;
    logic          w_pop;
    logic          w_starve;

    // FIFO handshake: empty=0 means pixel_in holds a valid head word; r_e=1 is
    // the consumer's accept, and the word is consumed at the clk edge where r_e=1.
    // Only ACTIVE cycles ever accept, so words arriving during blanking wait.
    assign w_pop      = (r_state == ACTIVE) && !empty;
    assign w_starve   = (r_state == ACTIVE) && empty;
    assign r_e        = w_pop;
    assign w_line_end = (r_h_cnt == H_LAST);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_h_next     = r_h_cnt;
        w_v_next     = r_v_cnt;
        w_start      = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            IDLE: begin
                w_h_next = '0;
                w_v_next = '0;
                if (enable && !empty) begin
                    w_state_next = ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ACTIVE: begin
                w_h_next = r_h_cnt + 1'b1;
                if (r_h_cnt == H_ACT_LAST) w_state_next = HBLANK;
            end
            HBLANK: begin
                if (w_line_end) begin
                    w_h_next     = '0;
                    w_v_next     = r_v_cnt + 1'b1;
                    w_state_next = (r_v_cnt < V_ACT_LAST) ? ACTIVE : VBLANK;
                end else begin
                    w_h_next = r_h_cnt + 1'b1;
                end
            end
            VBLANK: begin
                if (w_line_end) begin
                    w_h_next = '0;
                    if (r_v_cnt == V_LAST) begin
                        // Last cycle of the frame: enable is re-sampled here only.
                        w_frame_end  = 1'b1;
                        w_v_next     = '0;
                        w_state_next = (enable && !empty) ? ACTIVE : IDLE;
                    end else begin
                        w_v_next = r_v_cnt + 1'b1;
                    end
                end else begin
                    w_h_next = r_h_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            pixel_out   <= 8'h00;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            pixel_out   <= w_pop ? pixel_in : 8'h00;
            line_valid  <= (r_state == ACTIVE);
            frame_valid <= (r_state == ACTIVE) || (r_state == HBLANK);
            frame_done  <= w_frame_end;
            if (w_start) begin
                underflow <= 1'b0;
            end else if (w_starve) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_out_gen.sv
// Bench for video_out_gen on a tiny 4x2 raster: a queue-backed FIFO and a
// frame-position reference model predict r_e and every registered output.
module tb_video_out_gen;

    localparam int WIDTH   = 4;
    localparam int HEIGHT  = 2;
    localparam int H_BLANK = 2;
    localparam int V_BLANK = 1;
    localparam int H_TOTAL = WIDTH + H_BLANK;
    localparam int FRAME   = H_TOTAL * (HEIGHT + V_BLANK);

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       enable = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] pixel_in = 8'h00;
    logic       r_e;
    logic [7:0] pixel_out;
    logic       line_valid;
    logic       frame_valid;
    logic       frame_done;
    logic       underflow;

    // ---------------- clock / reset
    always #5 clk = ~clk;

    video_out_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .H_BLANK(H_BLANK),
        .V_BLANK(V_BLANK)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .enable     (enable),
        .empty      (empty),
        .pixel_in   (pixel_in),
        .r_e        (r_e),
        .pixel_out  (pixel_out),
        .line_valid (line_valid),
        .frame_valid(frame_valid),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    // ---------------- FIFO model and reference model state
    logic [7:0] fifo_q[$];
    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    int         cyc    = 0;
    int         fd_count = 0;
    int         lv_rise[$];
    logic       prev_lv = 1'b0;

    bit         m_run = 1'b0;
    int         m_pos = 0;
    logic       m_uf = 1'b0;
    logic       m_re = 1'b0;
    logic       m_lv = 1'b0;
    logic       m_fv = 1'b0;
    logic       m_fd = 1'b0;
    logic [7:0] m_px = 8'h00;

    // ---------------- scoreboard
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- driver tasks
    task automatic fifo_refresh();
        empty    = (fifo_q.size() == 0);
        pixel_in = empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        fifo_refresh();
    endtask

    // Frame described as a flat position 0..FRAME-1; line/column come from div/mod.
    task automatic model_step();
        int line;
        int col;
        bit act;
        if (!nRST) begin
            m_run = 1'b0; m_pos = 0; m_uf = 1'b0;
            m_re = 1'b0; m_lv = 1'b0; m_fv = 1'b0; m_fd = 1'b0; m_px = 8'h00;
        end else if (!m_run) begin
            m_re = 1'b0; m_lv = 1'b0; m_fv = 1'b0; m_fd = 1'b0; m_px = 8'h00;
            if (enable && fifo_q.size() != 0) begin
                m_run = 1'b1;
                m_pos = 0;
                m_uf  = 1'b0;
            end
        end else begin
            line = m_pos / H_TOTAL;
            col  = m_pos % H_TOTAL;
            act  = (line < HEIGHT) && (col < WIDTH);
            m_re = act && (fifo_q.size() != 0);
            m_lv = act;
            m_fv = (line < HEIGHT);
            m_px = m_re ? fifo_q[0] : 8'h00;
            if (act && fifo_q.size() == 0) m_uf = 1'b1;
            m_fd = (m_pos == FRAME - 1);
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos = 0;
                m_run = enable && (fifo_q.size() != 0);
            end
        end
    endtask

    // One clock: predict and check r_e mid-cycle, pop at the edge, check outputs after.
    task automatic cycle();
        logic pop;
        @(negedge clk);
        model_step();
        chk1("r_e", r_e, m_re);
        @(posedge clk);
        pop = r_e;
        #1;
        cyc++;
        if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_refresh();
        chk1("line_valid", line_valid, m_lv);
        chk1("frame_valid", frame_valid, m_fv);
        chk1("frame_done", frame_done, m_fd);
        chk1("underflow", underflow, m_uf);
        chk8("pixel_out", pixel_out, m_px);
        if (frame_done) fd_count++;
        if (line_valid && !prev_lv) lv_rise.push_back(cyc);
        prev_lv = line_valid;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- directed + random sequence
    initial begin
        fifo_refresh();
        run(2);
        nRST = 1'b1;
        run(2);

        // Full frame from a preloaded FIFO.
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        enable = 1'b1;
        fd_count = 0;
        run(22);
        chk_int("frame1_done_pulses", fd_count, 1);
        chk1("frame1_no_underflow", underflow, 1'b0);

        // Short FIFO: last two active pixels starve.
        for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
        run(22);
        chk1("short_fifo_underflow", underflow, 1'b1);

        // Back-to-back frames.
        lv_rise.delete();
        fd_count = 0;
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        run(42);
        chk_int("b2b_done_pulses", fd_count, 2);
        chk_int("b2b_line_starts", lv_rise.size(), 4);
        if (lv_rise.size() >= 3) chk_int("b2b_frame_period", lv_rise[2] - lv_rise[0], FRAME);

        // enable dropped at the second active pixel; an extra word stays queued.
        fd_count = 0;
        for (int i = 0; i < 9; i++) push(8'h60 + 8'(i));
        run(2);
        enable = 1'b0;
        run(24);
        chk_int("disable_done_pulses", fd_count, 1);
        chk_int("disable_leftover", fifo_q.size(), 1);

        // Asynchronous reset at the third active pixel.
        for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
        enable = 1'b1;
        run(3);
        #2 nRST = 1'b0;
        #1;
        chk1("rst_r_e", r_e, 1'b0);
        chk1("rst_line_valid", line_valid, 1'b0);
        chk1("rst_frame_valid", frame_valid, 1'b0);
        chk1("rst_frame_done", frame_done, 1'b0);
        chk1("rst_underflow", underflow, 1'b0);
        chk8("rst_pixel_out", pixel_out, 8'h00);
        run(2);
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h90 + 8'(i));
        run(40);

        // Enabled but empty: must idle, then start on the first pushed word.
        run(20);
        push(8'hA5);
        run(22);

        // Randomised traffic and enable toggling.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 24) push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
